mc_control_fsm: RTL

//  Multicycle MIPS main controller, directly upstream of aludec: sequences each instruction

---
 rtl/mc_control_fsm_pkg.sv | 66 ++++++
 rtl/mc_out_decode.sv | 72 +++++++
 rtl/mc_control_fsm.sv | 97 +++++++++
 3 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Holds opcode constants, ALU-op codes for aludec, datapath select codes,
// the state encoding (FETCH=0 ... JEX=11) and the packed control word that
// the output decoder produces for each state.
package mc_control_fsm_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // alu_op codes consumed by aludec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Moore control word; pc_write and branch stay internal and are merged
  // into pc_en by the top level together with the ALU zero flag.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// State -> control word decoder for the multicycle MIPS controller.
// Purely combinational; every field defaults to 0 and only the values a
// state needs are raised. Unencoded state values produce an all-zero word.
// Ports:
//   state  in  4   current controller state
//   ctrl   out     packed control word (ctrl_t)
module mc_out_decode
  import mc_control_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JEX: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller (upstream of aludec).
// Sequences lw, sw, R-type, beq, addi and j through FETCH/DECODE/EXEC/MEM/WB;
// any other opcode returns to FETCH straight after DECODE.
// Ports:
//   clk, rst        clock, synchronous active-high reset (forces FETCH)
//   op              opcode from the instruction register
//   zero            ALU zero flag, meaningful in BEQEX
//   pc_en           pc_write | (branch & zero)
//   iord .. pc_src  datapath enables/selects (Moore, from current state)
//   state_dbg       current state encoding
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_next = S_MEMRD;
        end else if (op == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Output logic: Moore decode plus the zero-qualified PC enable
  mc_out_decode u_out_decode (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  always_comb begin
    pc_en      = ctrl.pc_write | (ctrl.branch & zero);
    iord       = ctrl.iord;
    mem_write  = ctrl.mem_write;
    ir_write   = ctrl.ir_write;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    reg_write  = ctrl.reg_write;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    alu_op     = ctrl.alu_op;
    pc_src     = ctrl.pc_src;
    state_dbg  = state_reg;
  end

endmodule
